// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline hazard blocks: stall FSM encoding
// and register-index constants.
package mips_pipe_pkg;

    localparam int REG_W_DEF = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_WAIT2 = 1'b1
    } stall_state_e;

endpackage

// File: rtl/hazard_match.sv
// Combinational operand comparator: raises the load-use and branch-in-ID
// hazard terms from the ID, EX and MEM register fields.
module hazard_match
    import mips_pipe_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] RsID,
    input  logic [REG_W-1:0] RtID,
    input  logic             UsesRtID,
    input  logic             BranchID,
    input  logic             MemReadEX,
    input  logic             RegWriteEX,
    input  logic [REG_W-1:0] RdEX,
    input  logic             MemReadM,
    input  logic [REG_W-1:0] RdM,
    output logic             lu_haz,
    output logic             br_alu_haz,
    output logic             br_ld_haz,
    output logic             br_mem_haz
);

    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(REG_ZERO);

    logic ex_nz_s;
    logic m_nz_s;
    logic m_ex_s_s;
    logic m_ex_t_s;
    logic ex_any_s;
    logic m_m_s;

    // Register 0 is hardwired, so a zero destination never creates a dependency.
    always_comb begin
        ex_nz_s    = (RdEX != ZERO_IDX);
        m_nz_s     = (RdM != ZERO_IDX);
        m_ex_s_s   = ex_nz_s & (RdEX == RsID);
        m_ex_t_s   = ex_nz_s & (RdEX == RtID) & UsesRtID;
        ex_any_s   = ex_nz_s & ((RdEX == RsID) | (RdEX == RtID));
        m_m_s      = m_nz_s & ((RdM == RsID) | (RdM == RtID));
        lu_haz     = MemReadEX & (m_ex_s_s | m_ex_t_s);
        br_alu_haz = BranchID & RegWriteEX & ~MemReadEX & ex_any_s;
        br_ld_haz  = BranchID & MemReadEX & ex_any_s;
        br_mem_haz = BranchID & MemReadM & m_m_s;
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for hazards that forwarding cannot resolve, with a
// two-cycle branch-after-load FSM and a saturating stall-cycle counter.
module hazard_stall_unit
    import mips_pipe_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int REG_W = REG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] RsID,
    input  logic [REG_W-1:0] RtID,
    input  logic             UsesRtID,
    input  logic             BranchID,
    input  logic             PCSrcID,
    input  logic             JumpID,
    input  logic             MemReadEX,
    input  logic             RegWriteEX,
    input  logic [REG_W-1:0] RdEX,
    input  logic             MemReadM,
    input  logic [REG_W-1:0] RdM,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] StallCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    stall_state_e     state_r;
    stall_state_e     state_nxt_s;
    logic             stall_s;
    logic [CNT_W-1:0] count_r;
    logic             lu_haz_s;
    logic             br_alu_haz_s;
    logic             br_ld_haz_s;
    logic             br_mem_haz_s;

    hazard_match #(
        .REG_W (REG_W)
    ) u_match (
        .RsID       (RsID),
        .RtID       (RtID),
        .UsesRtID   (UsesRtID),
        .BranchID   (BranchID),
        .MemReadEX  (MemReadEX),
        .RegWriteEX (RegWriteEX),
        .RdEX       (RdEX),
        .MemReadM   (MemReadM),
        .RdM        (RdM),
        .lu_haz     (lu_haz_s),
        .br_alu_haz (br_alu_haz_s),
        .br_ld_haz  (br_ld_haz_s),
        .br_mem_haz (br_mem_haz_s)
    );

    // Stall FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and stall decision; WAIT2 covers the load's MEM cycle blindly.
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (br_ld_haz_s) begin
                    stall_s     = 1'b1;
                    state_nxt_s = ST_WAIT2;
                end else if (lu_haz_s | br_alu_haz_s | br_mem_haz_s) begin
                    stall_s     = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    stall_s     = 1'b0;
                    state_nxt_s = ST_RUN;
                end
            end
            ST_WAIT2: begin
                stall_s     = 1'b1;
                state_nxt_s = ST_RUN;
            end
            default: begin
                stall_s     = 1'b0;
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Pipeline control; a stalled branch has unresolved operands so it must not flush.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushE = 1'b0;
        FlushD = 1'b0;
        if (!rst) begin
            StallF = 1'b0;
            StallD = 1'b0;
            FlushE = 1'b0;
            FlushD = 1'b0;
        end else begin
            StallF = stall_s;
            StallD = stall_s;
            FlushE = stall_s;
            FlushD = (PCSrcID | JumpID) & ~stall_s;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (stall_s && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign StallCount = count_r;

endmodule
